// File: rtl/wb_commit_queue.sv
// In-order write-back commit queue: MEM results wait in DEPTH slots, loads collect tagged
// out-of-order memory data, and the head retires one entry per cycle to the register-file port.
module wb_commit_queue #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PTR_W-1:0] in_tag,
    input  logic             reg_write,
    input  logic             mem_to_reg,
    input  logic             lui_ctrl,
    input  logic             jump,
    input  logic             jalr,
    input  logic [2:0]       load_funct3,
    input  logic [RA_W-1:0]  rd,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  pc_plus_4,
    input  logic [XLEN-1:0]  lui_imm,
    input  logic             mem_rvalid,
    input  logic [PTR_W-1:0] mem_rtag,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d, filled_q, filled_d;
    logic [DEPTH-1:0] load_q, load_d, regw_q, regw_d;
    logic [RA_W-1:0]  rd_q [DEPTH];
    logic [RA_W-1:0]  rd_d [DEPTH];
    logic [XLEN-1:0]  val_q [DEPTH];
    logic [XLEN-1:0]  val_d [DEPTH];
    logic [XLEN-1:0]  mdata_q [DEPTH];
    logic [XLEN-1:0]  mdata_d [DEPTH];
    logic [2:0]       f3_q [DEPTH];
    logic [2:0]       f3_d [DEPTH];
    logic             rf_we_q, rf_we_d, err_q, err_d;
    logic [RA_W-1:0]  rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]  rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    logic             full, push, pop, cap_err, bad_f3;
    logic [PTR_W-1:0] head;
    logic [1:0]       off;
    logic [XLEN-1:0]  h_word, ld_val, ret_val;
    logic [7:0]       h_byte;
    logic [15:0]      h_half;

    // in_valid/in_ready: an entry transfers on every rising edge where both are high; in_ready
    // reflects occupancy only, so a full queue refuses a push even while its head retires.
    always_comb begin
        full     = (count_q == FULL_CNT);
        push     = in_valid && !full;
        head     = rd_ptr_q;
        pop      = valid_q[head] && (!load_q[head] || filled_q[head]);
        cap_err  = mem_rvalid && (!valid_q[mem_rtag] || !load_q[mem_rtag] || filled_q[mem_rtag] ||
                                  (push && (wr_ptr_q == mem_rtag)));

        h_word   = mdata_q[head];
        off      = val_q[head][1:0];
        h_byte   = h_word[{off, 3'b000} +: 8];
        h_half   = off[1] ? h_word[16 +: 16] : h_word[0 +: 16];
        bad_f3   = 1'b0;
        case (f3_q[head])
            3'b000:  ld_val = {{(XLEN-8){h_byte[7]}}, h_byte};
            3'b001:  ld_val = {{(XLEN-16){h_half[15]}}, h_half};
            3'b010:  ld_val = h_word;
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, h_byte};
            3'b101:  ld_val = {{(XLEN-16){1'b0}}, h_half};
            default: begin
                ld_val = h_word;
                bad_f3 = 1'b1;
            end
        endcase
        // Non-load slots already hold their selected value; load slots hold the address.
        ret_val  = load_q[head] ? ld_val : val_q[head];

        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        valid_d      = valid_q;
        filled_d     = filled_q;
        load_d       = load_q;
        regw_d       = regw_q;
        rd_d         = rd_q;
        val_d        = val_q;
        mdata_d      = mdata_q;
        f3_d         = f3_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        retire_cnt_d = retire_cnt_q;
        err_d        = err_q | cap_err;

        if (push) begin
            valid_d[wr_ptr_q]  = 1'b1;
            filled_d[wr_ptr_q] = 1'b0;
            load_d[wr_ptr_q]   = mem_to_reg;
            regw_d[wr_ptr_q]   = reg_write;
            rd_d[wr_ptr_q]     = rd;
            f3_d[wr_ptr_q]     = load_funct3;
            if (mem_to_reg)          val_d[wr_ptr_q] = alu_result;
            else if (jump || jalr)   val_d[wr_ptr_q] = pc_plus_4;
            else if (lui_ctrl)       val_d[wr_ptr_q] = lui_imm;
            else                     val_d[wr_ptr_q] = alu_result;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (mem_rvalid && !cap_err) begin
            filled_d[mem_rtag] = 1'b1;
            mdata_d[mem_rtag]  = mem_rdata;
        end

        if (pop) begin
            valid_d[head]  = 1'b0;
            filled_d[head] = 1'b0;
            rd_ptr_d       = rd_ptr_q + PTR_W'(1);
            retire_cnt_d   = retire_cnt_q + CNT_W'(1);
            rf_we_d        = regw_q[head] && (rd_q[head] != '0);
            rf_waddr_d     = rd_q[head];
            rf_wdata_d     = ret_val;
            if (load_q[head] && bad_f3) err_d = 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            filled_q     <= '0;
            load_q       <= '0;
            regw_q       <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            err_q        <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            filled_q     <= filled_d;
            load_q       <= load_d;
            regw_q       <= regw_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            err_q        <= err_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Payload storage is qualified by the valid/filled flags, so it needs no reset.
    always_ff @(posedge clk) begin
        rd_q    <= rd_d;
        val_q   <= val_d;
        mdata_q <= mdata_d;
        f3_q    <= f3_d;
    end

    assign in_ready   = !full;
    assign in_tag     = wr_ptr_q;
    assign busy       = (count_q != '0);
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign err        = err_q;
    assign retire_cnt = retire_cnt_q;

endmodule
